// File: rtl/coeff_bus_ctrl_if.sv
// Command/response handshake and DSP coefficient port bundled for the coefficient sequencer.
// The slave modport is the sequencer's view and the master modport is the decoder/DSP side.
interface coeff_bus_ctrl_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [9:0]  cmd_addr;
   logic [7:0]  cmd_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [7:0]  rsp_rdata;
   logic        rsp_err;
   logic        msg_in;
   logic        coeff_rw;
   logic [9:0]  coeff_addr;
   logic [7:0]  coeff_in;
   logic [7:0]  coeff_read_out;
   logic        flush_req;
   logic [15:0] wr_count;

   modport slave (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, coeff_read_out,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err, msg_in, coeff_rw, coeff_addr,
             coeff_in, flush_req, wr_count
   );

   modport master (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, coeff_read_out,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, msg_in, coeff_rw, coeff_addr,
             coeff_in, flush_req, wr_count
   );
endinterface

// File: rtl/coeff_bus_ctrl.sv
// Single-beat coefficient command sequencer: decodes the global map, mirrors broadcast
// writes into both banks, times reads and returns responses with backpressure.
module coeff_bus_ctrl #(
   parameter int unsigned READ_LAT = 2,
   parameter int unsigned NUM_TAPS = 71,
   parameter int unsigned I_BASE   = 128,
   parameter int unsigned Q_BASE   = 256,
   parameter int unsigned BC_BASE  = 512
) (
   input logic            clk,
   input logic            rst,
   coeff_bus_ctrl_if.slave bus
);

   localparam int unsigned CntW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

   typedef enum logic [2:0] {StIdle, StWrI, StWrQ, StRdDrv, StRdCap, StResp} state_e;

   state_e          state_q;
   logic            msg_in_q;
   logic            coeff_rw_q;
   logic [9:0]      coeff_addr_q;
   logic [7:0]      coeff_in_q;
   logic            rsp_valid_q;
   logic [7:0]      rsp_rdata_q;
   logic            rsp_err_q;
   logic            flush_req_q;
   logic [15:0]     wr_count_q;
   logic [9:0]      off_q;
   logic            bc_q;
   logic [CntW-1:0] cnt_q;

   logic [10:0] addr_x;
   logic        in_i;
   logic        in_q;
   logic        in_bc;
   logic        dec_err;
   logic [9:0]  dec_off;
   logic [9:0]  dec_addr;

   always_comb begin
      addr_x  = {1'b0, bus.cmd_addr};
      in_i    = (addr_x >= 11'(I_BASE)) && (addr_x < 11'(I_BASE + NUM_TAPS));
      in_q    = (addr_x >= 11'(Q_BASE)) && (addr_x < 11'(Q_BASE + NUM_TAPS));
      in_bc   = (addr_x >= 11'(BC_BASE)) && (addr_x < 11'(BC_BASE + NUM_TAPS));
      dec_err = !(in_i || in_q || (in_bc && bus.cmd_write));
      dec_off = bus.cmd_addr - 10'(BC_BASE);
      if (in_i) begin
         dec_off = bus.cmd_addr - 10'(I_BASE);
      end else if (in_q) begin
         dec_off = bus.cmd_addr - 10'(Q_BASE);
      end
      // Broadcast writes land on the I bank first; the Q strobe follows from off_q.
      dec_addr = in_bc ? (10'(I_BASE) + dec_off) : bus.cmd_addr;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         msg_in_q     <= 1'b0;
         coeff_rw_q   <= 1'b0;
         coeff_addr_q <= '0;
         coeff_in_q   <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_rdata_q  <= '0;
         rsp_err_q    <= 1'b0;
         flush_req_q  <= 1'b0;
         wr_count_q   <= '0;
         off_q        <= '0;
         bc_q         <= 1'b0;
         cnt_q        <= '0;
      end else begin
         flush_req_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (bus.cmd_valid) begin
                  off_q       <= dec_off;
                  bc_q        <= in_bc;
                  rsp_rdata_q <= '0;
                  rsp_err_q   <= 1'b0;
                  if (dec_err) begin
                     state_q     <= StResp;
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 1'b1;
                  end else if (bus.cmd_write) begin
                     state_q      <= StWrI;
                     msg_in_q     <= 1'b1;
                     coeff_rw_q   <= 1'b1;
                     coeff_addr_q <= dec_addr;
                     coeff_in_q   <= bus.cmd_wdata;
                  end else begin
                     state_q      <= StRdDrv;
                     msg_in_q     <= 1'b1;
                     coeff_rw_q   <= 1'b0;
                     coeff_addr_q <= dec_addr;
                     cnt_q        <= CntW'(READ_LAT - 1);
                  end
               end
            end
            StWrI, StWrQ: begin
               if (wr_count_q != 16'hFFFF) begin
                  wr_count_q <= wr_count_q + 16'd1;
               end
               if ((state_q == StWrI) && bc_q) begin
                  state_q      <= StWrQ;
                  coeff_addr_q <= 10'(Q_BASE) + off_q;
               end else begin
                  state_q      <= StResp;
                  msg_in_q     <= 1'b0;
                  coeff_rw_q   <= 1'b0;
                  coeff_addr_q <= '0;
                  coeff_in_q   <= '0;
                  rsp_valid_q  <= 1'b1;
                  flush_req_q  <= 1'b1;
               end
            end
            StRdDrv: begin
               if (cnt_q == '0) begin
                  state_q  <= StRdCap;
                  msg_in_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            StRdCap: begin
               state_q      <= StResp;
               coeff_addr_q <= '0;
               rsp_rdata_q  <= bus.coeff_read_out;
               rsp_valid_q  <= 1'b1;
            end
            StResp: begin
               if (bus.rsp_ready) begin
                  state_q     <= StIdle;
                  rsp_valid_q <= 1'b0;
                  rsp_rdata_q <= '0;
                  rsp_err_q   <= 1'b0;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.cmd_ready  = (state_q == StIdle) && !rst;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_rdata  = rsp_rdata_q;
   assign bus.rsp_err    = rsp_err_q;
   assign bus.msg_in     = msg_in_q;
   assign bus.coeff_rw   = coeff_rw_q;
   assign bus.coeff_addr = coeff_addr_q;
   assign bus.coeff_in   = coeff_in_q;
   assign bus.flush_req  = flush_req_q;
   assign bus.wr_count   = wr_count_q;

endmodule
